// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package cache_pkg;
   localparam int LINES    = 16;
   localparam int WORDS    = 4;
   localparam int ADDR_W   = 32;
   localparam int WSEL_W   = $clog2(WORDS);
   localparam int OFFSET_W = WSEL_W + 2;
   localparam int INDEX_W  = $clog2(LINES);
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [TAG_W-1:0] tag;
   } meta_t;
endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty/tag per line plus data words; async read, byte-enable write.
module dcache_array
   import cache_pkg::*;
#(
   parameter int LINES = cache_pkg::LINES,
   parameter int WORDS = cache_pkg::WORDS
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [INDEX_W-1:0] idx_i,
   input  logic [WSEL_W-1:0]  wsel_i,
   output meta_t              meta_o,
   output logic [31:0]        rdata_o,
   input  logic               wr_en_i,
   input  logic [3:0]         be_i,
   input  logic [31:0]        wdata_i,
   input  logic               meta_we_i,
   input  meta_t              meta_i
);
   logic [LINES-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES][WORDS];

   assign meta_o  = '{valid: valid_q[idx_i], dirty: dirty_q[idx_i], tag: tag_q[idx_i]};
   assign rdata_o = data_q[idx_i][wsel_i];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (meta_we_i) begin
         valid_q[idx_i] <= meta_i.valid;
         dirty_q[idx_i] <= meta_i.dirty;
      end
   end

   // Tags and data carry no reset; valid bits gate their use.
   always_ff @(posedge clock) begin
      if (meta_we_i) tag_q[idx_i] <= meta_i.tag;
      if (wr_en_i)
         for (int b = 0; b < 4; b++)
            if (be_i[b]) data_q[idx_i][wsel_i][8*b +: 8] <= wdata_i[8*b +: 8];
   end
endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache with miss FSM and hit/miss counters.
module dcache_wb
   import cache_pkg::*;
#(
   parameter int LINES  = cache_pkg::LINES,
   parameter int WORDS  = cache_pkg::WORDS,
   parameter int ADDR_W = cache_pkg::ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic              cpu_sb,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);
   localparam logic [WSEL_W-1:0] LAST = WSEL_W'(WORDS - 1);

   state_e              state_q, state_d;
   logic [WSEL_W-1:0]   cnt_q, cnt_d;
   logic                replay_q, replay_d;
   logic [31:0]         hit_q, miss_q;

   logic [INDEX_W-1:0]  idx;
   logic [WSEL_W-1:0]   wsel, arr_wsel;
   logic [TAG_W-1:0]    tag;
   meta_t               meta, meta_wr;
   logic [31:0]         arr_rdata, arr_wdata, rdata_c, mwdata_c;
   logic [ADDR_W-1:0]   maddr_c;
   logic [3:0]          be;
   logic                access, tag_hit, arr_we, meta_we;
   logic                stall_c, req_c, we_c, hit_ev, miss_ev;

   assign idx    = cpu_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
   assign wsel   = cpu_addr[OFFSET_W-1:2];
   assign tag    = cpu_addr[ADDR_W-1:OFFSET_W+INDEX_W];
   assign access = cpu_read | cpu_write;

   dcache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
      .clock    (clock),
      .reset    (reset),
      .idx_i    (idx),
      .wsel_i   (arr_wsel),
      .meta_o   (meta),
      .rdata_o  (arr_rdata),
      .wr_en_i  (arr_we),
      .be_i     (be),
      .wdata_i  (arr_wdata),
      .meta_we_i(meta_we),
      .meta_i   (meta_wr)
   );

   assign tag_hit = meta.valid && (meta.tag == tag);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      replay_d  = 1'b0;
      arr_wsel  = wsel;
      arr_we    = 1'b0;
      be        = 4'h0;
      arr_wdata = cpu_wdata;
      meta_we   = 1'b0;
      meta_wr   = '{valid: 1'b1, dirty: 1'b1, tag: tag};
      stall_c   = 1'b0;
      req_c     = 1'b0;
      we_c      = 1'b0;
      maddr_c   = '0;
      mwdata_c  = '0;
      rdata_c   = '0;
      hit_ev    = 1'b0;
      miss_ev   = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (tag_hit) begin
                  // The replayed access after a refill was already counted as a miss.
                  hit_ev  = !replay_q;
                  rdata_c = arr_rdata;
                  if (cpu_write) begin
                     arr_we    = 1'b1;
                     meta_we   = 1'b1;
                     be        = cpu_sb ? (4'b0001 << cpu_addr[1:0]) : 4'hF;
                     arr_wdata = cpu_sb ? {4{cpu_wdata[7:0]}} : cpu_wdata;
                  end
               end else begin
                  stall_c = 1'b1;
                  miss_ev = 1'b1;
                  state_d = (meta.valid && meta.dirty) ? WRITEBACK : REFILL;
               end
            end
         end
         WRITEBACK: begin
            stall_c  = 1'b1;
            arr_wsel = cnt_q;
            req_c    = 1'b1;
            we_c     = 1'b1;
            maddr_c  = {meta.tag, idx, cnt_q, 2'b00};
            mwdata_c = arr_rdata;
            if (mem_ack) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = REFILL;
               end
            end
         end
         REFILL: begin
            stall_c  = 1'b1;
            arr_wsel = cnt_q;
            req_c    = 1'b1;
            maddr_c  = {tag, idx, cnt_q, 2'b00};
            if (mem_ack) begin
               arr_we    = 1'b1;
               be        = 4'hF;
               arr_wdata = mem_rdata;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d    = '0;
                  meta_we  = 1'b1;
                  meta_wr  = '{valid: 1'b1, dirty: 1'b0, tag: tag};
                  state_d  = IDLE;
                  replay_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         replay_q <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         replay_q <= replay_d;
         if (hit_ev && hit_q != '1)   hit_q  <= hit_q + 1'b1;
         if (miss_ev && miss_q != '1) miss_q <= miss_q + 1'b1;
      end
   end

   // Reset forces the handshake and stall low even while a request is still presented.
   assign stall      = stall_c & reset;
   assign mem_req    = req_c & reset;
   assign mem_we     = we_c & reset;
   assign mem_addr   = maddr_c;
   assign mem_wdata  = mwdata_c;
   assign cpu_rdata  = reset ? rdata_c : 32'h0;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: vector table for hit behaviour, scoreboarded memory model for misses.
module tb_dcache_wb;
   logic        clock = 0, reset = 0;
   logic        cpu_read = 0, cpu_write = 0, cpu_sb = 0;
   logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
   logic        stall, mem_req, mem_we, mem_ack = 0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, hit_count, miss_count;

   dcache_wb dut (
      .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_sb(cpu_sb), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clock = ~clock;

   int vec_n = 0, err_n = 0, acks = 0, wait_c = 0;

   typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } memop_t;
   memop_t exp_q[$];
   logic [31:0] mem_m [int unsigned];

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      vec_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic void push_line(logic we, logic [31:0] base, logic [31:0] d0,
                                     logic [31:0] d1, logic [31:0] d2, logic [31:0] d3);
      exp_q.push_back('{we, base,       d0});
      exp_q.push_back('{we, base + 4,   d1});
      exp_q.push_back('{we, base + 8,   d2});
      exp_q.push_back('{we, base + 12,  d3});
   endfunction

   // Backing memory: acks two cycles after req is seen, one-cycle pulse, checks each op.
   always @(negedge clock) begin
      if (!reset) begin
         mem_ack = 0;
         wait_c  = 0;
      end else if (mem_ack) begin
         mem_ack = 0;
         wait_c  = 0;
      end else if (mem_req) begin
         wait_c++;
         if (wait_c == 2) begin
            memop_t e;
            mem_ack = 1;
            acks++;
            if (exp_q.size() == 0) begin
               check("memop_unexpected", mem_addr, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("mem_we", {31'h0, mem_we}, {31'h0, e.we});
               check("mem_addr", mem_addr, e.addr);
               if (e.we) check("mem_wdata", mem_wdata, e.data);
            end
            if (mem_we) mem_m[mem_addr] = mem_wdata;
            else mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr]
                                                    : 32'hA0 + {28'h0, mem_addr[3:2]};
         end
      end else begin
         wait_c = 0;
      end
   end

   // Presents one access, waits out any stall, samples rdata, then commits on a clock edge.
   task automatic access(input logic rd, wr, sb, input logic [31:0] addr, wdata,
                         output logic first_stall, output logic [31:0] rdata);
      int n = 0;
      @(negedge clock);
      cpu_read = rd; cpu_write = wr; cpu_sb = sb; cpu_addr = addr; cpu_wdata = wdata;
      #1 first_stall = stall;
      while (stall && n < 400) begin
         n++;
         @(negedge clock);
         #1;
      end
      if (stall) check("stall_timeout", 32'd1, 32'd0);
      rdata = cpu_rdata;
      @(posedge clock);
      #1 cpu_read = 0; cpu_write = 0; cpu_sb = 0;
   endtask

   typedef struct {
      logic rd, wr, sb;
      logic [31:0] addr, wdata;
      logic chk;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vt[8];

   initial begin
      logic fs;
      logic [31:0] rd;
      int a0, n;

      vt[0] = '{1, 0, 0, 32'h44, 32'h0,        1, 32'h0000_00A1};
      vt[1] = '{0, 1, 1, 32'h41, 32'h0000_00EE, 0, 32'h0};
      vt[2] = '{1, 0, 0, 32'h40, 32'h0,        1, 32'h0000_EEA0};
      vt[3] = '{0, 1, 1, 32'h4E, 32'hABCD_EF77, 0, 32'h0};
      vt[4] = '{1, 0, 0, 32'h4C, 32'h0,        1, 32'h0077_00A3};
      vt[5] = '{1, 1, 0, 32'h48, 32'h1234_5678, 0, 32'h0};
      vt[6] = '{1, 0, 0, 32'h48, 32'h0,        1, 32'h1234_5678};
      vt[7] = '{0, 0, 0, 32'h44, 32'h0,        1, 32'h0};

      repeat (3) @(negedge clock);
      check("rst_stall", {31'h0, stall}, 0);
      check("rst_mem_req", {31'h0, mem_req}, 0);
      check("rst_mem_we", {31'h0, mem_we}, 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_hits", hit_count, 0);
      check("rst_misses", miss_count, 0);
      reset = 1;

      // Cold miss, refill only
      push_line(0, 32'h40, 0, 0, 0, 0);
      a0 = acks;
      access(1, 0, 0, 32'h40, 0, fs, rd);
      check("cold_stall", {31'h0, fs}, 1);
      check("cold_rdata", rd, 32'hA0);
      check("cold_acks", acks - a0, 4);
      check("cold_misses", miss_count, 1);
      check("cold_hits", hit_count, 0);
      check("cold_q_empty", exp_q.size(), 0);

      // Hit traffic from the table: no stall, no memory traffic
      a0 = acks;
      for (int i = 0; i < 8; i++) begin
         access(vt[i].rd, vt[i].wr, vt[i].sb, vt[i].addr, vt[i].wdata, fs, rd);
         check($sformatf("vec%0d_stall", i), {31'h0, fs}, 0);
         if (vt[i].chk) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
         if (i == 0) check("vec0_hits", hit_count, 1);
      end
      check("hit_acks", acks - a0, 0);
      check("hit_count", hit_count, 7);
      check("hit_misses", miss_count, 1);

      // Conflict miss on a dirty line: write back then refill
      push_line(1, 32'h40, 32'h0000_EEA0, 32'hA1, 32'h1234_5678, 32'h0077_00A3);
      push_line(0, 32'h140, 0, 0, 0, 0);
      a0 = acks;
      access(1, 0, 0, 32'h140, 0, fs, rd);
      check("wb_stall", {31'h0, fs}, 1);
      check("wb_rdata", rd, 32'hA0);
      check("wb_acks", acks - a0, 8);
      check("wb_misses", miss_count, 2);
      check("wb_hits", hit_count, 7);
      check("wb_q_empty", exp_q.size(), 0);

      // Reset in the middle of a refill
      push_line(0, 32'h240, 0, 0, 0, 0);
      a0 = acks;
      @(negedge clock);
      cpu_read = 1; cpu_addr = 32'h240;
      n = 0;
      while (acks - a0 < 2 && n < 200) begin
         n++;
         @(negedge clock);
         #1;
      end
      check("rstmid_reach", acks - a0, 2);
      @(posedge clock);
      @(negedge clock);
      #2 reset = 0;
      #1;
      check("rstmid_mem_req", {31'h0, mem_req}, 0);
      check("rstmid_stall", {31'h0, stall}, 0);
      check("rstmid_rdata", cpu_rdata, 0);
      check("rstmid_hits", hit_count, 0);
      check("rstmid_misses", miss_count, 0);
      exp_q.delete();
      @(negedge clock);
      cpu_read = 0;
      reset = 1;

      push_line(0, 32'h140, 0, 0, 0, 0);
      access(1, 0, 0, 32'h140, 0, fs, rd);
      check("rerd_stall", {31'h0, fs}, 1);
      check("rerd_rdata", rd, 32'hA0);
      check("rerd_misses", miss_count, 1);
      check("rerd_q_empty", exp_q.size(), 0);

      // Written-back data comes back from memory
      push_line(0, 32'h40, 0, 0, 0, 0);
      access(1, 0, 0, 32'h48, 0, fs, rd);
      check("wbback_rdata", rd, 32'h1234_5678);
      check("wbback_misses", miss_count, 2);
      check("wbback_q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the EX/MEM pipeline buffer's MEM-stage outputs (ALU result address, store data, memWrite/sb, load request) and a multi-cycle backing data memory.
- Returns hit data in the same cycle. On a miss, asserts a stall that freezes the pipeline until the line is resident.
- Keeps hit/miss counters for the verification benches.

Parameters:
- LINES, 16, number of cache lines (power of 2).
- WORDS, 4, 32-bit words per line (power of 2).
- ADDR_W, 32, byte address width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_read  in  1  load request from MEM stage.
- cpu_write  in  1  store request (memWrite).
- cpu_sb  in  1  store-byte qualifier (with cpu_write).
- cpu_addr  in  ADDR_W  byte address (ALU result).
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, full word; sign-extension is done downstream.
- stall  out  1  freezes PC and all pipeline buffers while high.
- mem_req  out  1  backing-memory request, held until mem_ack.
- mem_we  out  1  1 = write word, 0 = read word.
- mem_addr  out  ADDR_W  word-aligned address.
- mem_wdata  out  32  write-back data.
- mem_rdata  in  32  refill data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse per word.
- hit_count  out  32  saturating count of hit accesses.
- miss_count  out  32  saturating count of misses.

Behaviour:
- Address split (defaults):
  - byte [1:0]
  - word [3:2]
  - index [7:4]
  - tag [ADDR_W-1:8]
- Per-line state: valid, dirty, tag, WORDS data words.
- Reset (async, reset=0):
  - all valid and dirty bits cleared; data arrays need not clear.
  - FSM to IDLE; word counter 0.
  - counters 0; mem_req=0, mem_we=0, stall=0, cpu_rdata=0.
  - An in-flight memory transaction is abandoned; the memory model must tolerate a dropped req.
- Request: access = cpu_read | cpu_write. If both are high, it is treated as a write.
- Hit (valid && tag match, state IDLE):
  - stall=0.
  - cpu_rdata is combinational from the array, zero latency.
  - A write updates the word at the clock edge and sets dirty.
  - With cpu_sb, only byte lane addr[1:0] is written (cpu_wdata[7:0]).
  - hit_count +1 per hit cycle.
- Miss in IDLE:
  - stall=1 combinationally, the same cycle.
  - miss_count +1 once, on the IDLE exit edge.
  - Next state is WRITEBACK if the victim is valid&&dirty, else REFILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, counter, 2'b00}, mem_wdata=victim word[counter].
  - On each mem_ack the counter increments.
  - On the ack of word WORDS-1: counter=0, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={cpu tag, index, counter, 2'b00}.
  - On each mem_ack, mem_rdata is written to word[counter].
  - On the last ack: tag, valid=1, dirty=0 set; go to IDLE.
- Back in IDLE the request re-evaluates as a hit: stall drops, and a write merges and sets dirty.
- mem_req may fall for at most the cycle after an ack.
- Miss latency: refill-only is WORDS acks + 1 IDLE cycle; with write-back add WORDS acks.
- cpu_rdata is 0 when stall=1 or when there is no access.
- Request inputs are stable while stall=1; the pipeline guarantees this, and the cache samples cpu_addr live.
- Counters saturate at 32'hFFFFFFFF. Hits are not counted while stall=1.

Decomposition:
- Shared package cache_pkg holds:
  - FSM state enum IDLE/WRITEBACK/REFILL.
  - localparams for INDEX_W, OFFSET_W, TAG_W, derived from LINES/WORDS/ADDR_W.
  - a line-metadata struct {valid, dirty, tag}.
- One natural sub-module, dcache_array: tag/valid/dirty/data storage with an async read port and a byte-enable write port. The FSM and counters stay in dcache_wb.

Test Plan:
- Cold read 0x00000040, memory returns 0xA0+word per word after 2 cycles → stall high for 4 acks + 1 cycle; cpu_rdata=0xA0; miss_count=1; mem_we never 1.
- Then read 0x00000044 → stall=0 same cycle; cpu_rdata=0xA1; hit_count=1.
- sb 0x00000041 with wdata 0x000000EE → word0 becomes 0x0000EEA0; line dirty; no memory traffic.
- Read 0x00000140 (same index, new tag) → 4 write acks to 0x40..0x4C with first data 0x0000EEA0, then 4 refill reads from 0x140..0x14C; miss_count=2.
- Assert reset low mid-REFILL (after the 2nd ack) → same cycle mem_req=0, stall=0, counters 0; re-read 0x140 misses again.
- cpu_read and cpu_write both high on a hit at 0x48 with wdata 0x12345678 → treated as write; subsequent read of 0x48 returns 0x12345678.
